// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Purpose : shared types and helpers for the interrupt request latch.
//           - state_t     : handshake FSM states (IDLE, OFFER)
//           - srcCount(n) : number of interrupt sources for an n-bit index
// Ports   : none (package)
// ---------------------------------------------------------------------------
package irq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Source count is always a power of two so the index uses every code.
    function automatic int srcCount(input int n);
        return 1 << n;
    endfunction

endpackage : irq_pkg

// File: rtl/lowest_set_index.sv
// ---------------------------------------------------------------------------
// lowest_set_index
// Purpose : purely combinational priority picker. Reports the index of the
//           lowest set bit of vec_i (bit 0 has the highest priority).
// Ports   :
//   vec_i  [2**N-1:0]  input  candidate vector
//   idx_o  [N-1:0]     output index of the lowest set bit, 0 when none_o=1
//   none_o             output 1 when vec_i has no bit set
// ---------------------------------------------------------------------------
module lowest_set_index
    import irq_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [(1<<N)-1:0] vec_i,
    output logic [N-1:0]      idx_o,
    output logic              none_o
);

    localparam int NS = srcCount(N);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        idx_o  = '0;
        none_o = 1'b1;
        for (int i = NS - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o  = N'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule : lowest_set_index

// File: rtl/irq_request_latch.sv
// ---------------------------------------------------------------------------
// irq_request_latch
// Purpose : captures rising edges on 2**N interrupt lines into sticky pending
//           bits, applies a software mask and offers the lowest-index
//           pending, unmasked source over a valid/ready handshake.
// Optional: define IRQ_OVERRUN_STATUS_EN to add the overrun status output,
//           which flags edges that arrived while the source was pending.
// Ports   :
//   clk                   input  clock, rising edge
//   rst_n                 input  asynchronous active-low reset
//   irq        [2**N-1:0] input  event lines, synchronous to clk
//   mask_we               input  mask write strobe
//   mask_wdata [2**N-1:0] input  new mask (1 = source blocked)
//   req_valid             output an index is being offered
//   req_id     [N-1:0]    output offered index, valid while req_valid=1
//   req_ready             input  consumer accepts the offered index
//   pending    [2**N-1:0] output pending bits (masked and unmasked)
//   mask       [2**N-1:0] output current mask register
//   overrun    [2**N-1:0] output merged-edge flags (IRQ_OVERRUN_STATUS_EN)
// ---------------------------------------------------------------------------
module irq_request_latch
    import irq_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [(1<<N)-1:0]   irq,
    input  logic                mask_we,
    input  logic [(1<<N)-1:0]   mask_wdata,
    output logic                req_valid,
    output logic [N-1:0]        req_id,
    input  logic                req_ready,
    output logic [(1<<N)-1:0]   pending,
`ifdef IRQ_OVERRUN_STATUS_EN
    output logic [(1<<N)-1:0]   overrun,
`endif
    output logic [(1<<N)-1:0]   mask
);

    localparam int NS = srcCount(N);

    logic [NS-1:0] irq_q;
    logic [NS-1:0] pending_q, pending_d;
    logic [NS-1:0] mask_q,    mask_d;
    logic [N-1:0]  req_id_q,  req_id_d;
    state_t        state_q,   state_d;

    logic [NS-1:0] rise;
    logic [NS-1:0] clr;
    logic [NS-1:0] elig;
    logic [N-1:0]  sel;
    logic          none;
    logic          accept;

    lowest_set_index #(.N(N)) u_pick (
        .vec_i  (elig),
        .idx_o  (sel),
        .none_o (none)
    );

    // Edge detection, eligibility and the one-hot clear of the accepted
    // source. A rise on the accepted bit overrides its clear so that event
    // is offered again later.
    always_comb begin
        rise      = irq & ~irq_q;
        elig      = pending_q & ~mask_q;
        accept    = (state_q == OFFER) && req_ready;
        clr       = '0;
        if (accept) begin
            clr[req_id_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    // Handshake FSM. The offer is frozen once made: neither a newly arriving
    // higher-priority source nor a mask write can change or withdraw it.
    always_comb begin
        state_d  = state_q;
        req_id_d = req_id_q;
        case (state_q)
            IDLE: begin
                if (!none) begin
                    state_d  = OFFER;
                    req_id_d = sel;
                end
            end
            OFFER: begin
                if (req_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset clears history so a line held high across
    // reset release counts as one event on the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            req_id_q  <= '0;
            state_q   <= IDLE;
        end else begin
            irq_q     <= irq;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            req_id_q  <= req_id_d;
            state_q   <= state_d;
        end
    end

`ifdef IRQ_OVERRUN_STATUS_EN
    logic [NS-1:0] overrun_q, overrun_d;

    // An edge on an already-pending source is an overrun; acceptance clears
    // the flag unless a fresh overrun lands in the same cycle.
    always_comb begin
        overrun_d = (overrun_q & ~clr) | (rise & pending_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

    assign req_valid = (state_q == OFFER);
    assign req_id    = req_id_q;
    assign pending   = pending_q;
    assign mask      = mask_q;

endmodule : irq_request_latch

// File: tb/tb_irq_request_latch.sv
// ---------------------------------------------------------------------------
// tb_irq_request_latch
// Purpose : self-checking bench for irq_request_latch with N=2. Directed
//           steps follow the functional scenarios, then a randomized phase
//           runs against a per-source behavioural model.
// Ports   : none (top-level bench)
// ---------------------------------------------------------------------------
module tb_irq_request_latch;

    localparam int N  = 2;
    localparam int NS = 4;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic [NS-1:0] irq        = '0;
    logic          mask_we    = 1'b0;
    logic [NS-1:0] mask_wdata = '0;
    logic          req_ready  = 1'b0;
    logic          req_valid;
    logic [N-1:0]  req_id;
    logic [NS-1:0] pending;
    logic [NS-1:0] mask;
`ifdef IRQ_OVERRUN_STATUS_EN
    logic [NS-1:0] overrun;
`endif

    irq_request_latch #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .req_valid  (req_valid),
        .req_id     (req_id),
        .req_ready  (req_ready),
        .pending    (pending),
`ifdef IRQ_OVERRUN_STATUS_EN
        .overrun    (overrun),
`endif
        .mask       (mask)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model: one sticky flag per source plus "offering which id".
    bit [NS-1:0] mPend;
    bit [NS-1:0] mMask;
    bit [NS-1:0] mPrev;
    bit [NS-1:0] mOvr;
    bit          mOffer;
    int          mId;

    int accIds[$];
    int accCyc[$];

    task automatic modelReset();
        mPend  = '0;
        mMask  = '0;
        mPrev  = '0;
        mOvr   = '0;
        mOffer = 1'b0;
        mId    = 0;
    endtask

    // Advance the model by one clock edge using the inputs present before it.
    task automatic modelEdge();
        bit [NS-1:0] np;
        bit [NS-1:0] no;
        int          lowest;
        np = mPend;
        no = mOvr;
        for (int i = 0; i < NS; i++) begin
            if (mOffer && req_ready && mId == i) begin
                np[i] = 1'b0;
                no[i] = 1'b0;
            end
            if (irq[i] && !mPrev[i]) begin
                if (mPend[i]) no[i] = 1'b1;
                np[i] = 1'b1;
            end
        end
        if (mOffer) begin
            if (req_ready) mOffer = 1'b0;
        end else begin
            lowest = -1;
            for (int i = NS - 1; i >= 0; i--) begin
                if (mPend[i] && !mMask[i]) lowest = i;
            end
            if (lowest >= 0) begin
                mOffer = 1'b1;
                mId    = lowest;
            end
        end
        if (mask_we) mMask = mask_wdata;
        mPrev = irq;
        mPend = np;
        mOvr  = no;
    endtask

    task automatic applyStimulus(input logic [NS-1:0] i, input logic we,
                                 input logic [NS-1:0] wd, input logic rdy);
        irq        = i;
        mask_we    = we;
        mask_wdata = wd;
        req_ready  = rdy;
    endtask

    task automatic checkOutput();
        logic [N-1:0] expId;
        expId = N'(mId);
        total++;
        assert (req_valid === mOffer) else begin
            bad++;
            $error("[TB] FAIL valid cyc=%0d got=%b exp=%b", cyc, req_valid, mOffer);
        end
        if (mOffer) begin
            total++;
            assert (req_id === expId) else begin
                bad++;
                $error("[TB] FAIL req_id cyc=%0d got=%0d exp=%0d", cyc, req_id, expId);
            end
        end
        total++;
        assert (pending === mPend) else begin
            bad++;
            $error("[TB] FAIL pending cyc=%0d got=%b exp=%b", cyc, pending, mPend);
        end
        total++;
        assert (mask === mMask) else begin
            bad++;
            $error("[TB] FAIL mask cyc=%0d got=%b exp=%b", cyc, mask, mMask);
        end
`ifdef IRQ_OVERRUN_STATUS_EN
        total++;
        assert (overrun === mOvr) else begin
            bad++;
            $error("[TB] FAIL overrun cyc=%0d got=%b exp=%b", cyc, overrun, mOvr);
        end
`endif
    endtask

    // Directed check against a value fixed by the scenario itself.
    task automatic checkValue(input string tag, input logic [7:0] got,
                              input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock: log DUT acceptances, advance model, check #1 after the edge.
    task automatic tick();
        if (rst_n && req_valid && req_ready) begin
            accIds.push_back(int'(req_id));
            accCyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        if (rst_n) modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        modelReset();
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
        #12;
        checkOutput();
        rst_n = 1'b1;

        // Reset then idle
        ticks(10);
        checkValue("idle_pending", 8'(pending), 8'h0);

        // Single event on source 2, held offer, then accept
        applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0);
        tick();
        checkValue("single_pending", 8'(pending), 8'h4);
        tick();
        checkValue("single_valid", 8'(req_valid), 8'h1);
        checkValue("single_id", 8'(req_id), 8'h2);
        ticks(5);
        checkValue("hold_id", 8'(req_id), 8'h2);
        req_ready = 1'b1;
        tick();
        checkValue("accept_valid", 8'(req_valid), 8'h0);
        checkValue("accept_pending", 8'(pending), 8'h0);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();

        // Priority order with ready held high
        accIds.delete();
        accCyc.delete();
        applyStimulus(4'b1111, 1'b0, 4'b0000, 1'b1);
        ticks(10);
        checkValue("prio_count", 8'(accIds.size()), 8'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < accIds.size()) begin
                checkValue("prio_id", 8'(accIds[k]), 8'(k));
                if (k > 0) checkValue("prio_gap", 8'(accCyc[k] - accCyc[k-1]), 8'd2);
            end
        end
        checkValue("prio_pending", 8'(pending), 8'h0);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();

        // No pre-emption
        applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0);
        ticks(2);
        irq = 4'b0101;
        ticks(3);
        checkValue("nopre_id", 8'(req_id), 8'h2);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        tick();
        checkValue("nopre_next_valid", 8'(req_valid), 8'h1);
        checkValue("nopre_next_id", 8'(req_id), 8'h0);
        req_ready = 1'b1;
        tick();
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();

        // Mask blocks offering, unmask releases it, masking mid-offer keeps it
        applyStimulus(4'b0000, 1'b1, 4'b0001, 1'b0);
        tick();
        applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0);
        tick();
        checkValue("mask_pending", 8'(pending), 8'h1);
        ticks(2);
        checkValue("mask_blocked", 8'(req_valid), 8'h0);
        applyStimulus(4'b0001, 1'b1, 4'b0000, 1'b0);
        tick();
        mask_we = 1'b0;
        tick();
        checkValue("unmask_valid", 8'(req_valid), 8'h1);
        checkValue("unmask_id", 8'(req_id), 8'h0);
        applyStimulus(4'b0001, 1'b1, 4'b0001, 1'b0);
        tick();
        checkValue("mask_mid_offer", 8'(req_valid), 8'h1);
        applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b1);
        tick();
        checkValue("mask_accept_pending", 8'(pending), 8'h0);
        applyStimulus(4'b0000, 1'b1, 4'b0000, 1'b0);
        tick();
        mask_we = 1'b0;
        tick();

        // Set/clear collision on source 1
        irq = 4'b0010;
        ticks(2);
        irq = 4'b0000;
        tick();
        applyStimulus(4'b0010, 1'b0, 4'b0000, 1'b1);
        tick();
        checkValue("collide_pending", 8'(pending), 8'h2);
        req_ready = 1'b0;
        tick();
        checkValue("collide_reoffer", 8'(req_id), 8'h1);
        req_ready = 1'b1;
        tick();
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();

        // Second edge on pending source 3
        irq = 4'b1000;
        tick();
        irq = 4'b0000;
        tick();
        irq = 4'b1000;
        tick();
`ifdef IRQ_OVERRUN_STATUS_EN
        checkValue("overrun_set", 8'(overrun), 8'h8);
`endif
        req_ready = 1'b1;
        tick();
`ifdef IRQ_OVERRUN_STATUS_EN
        checkValue("overrun_clear", 8'(overrun), 8'h0);
`endif
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();

        // Asynchronous reset in the middle of an offer
        irq = 4'b0001;
        ticks(2);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkValue("async_valid", 8'(req_valid), 8'h0);
        checkValue("async_pending", 8'(pending), 8'h0);
        checkOutput();
        rst_n = 1'b1;
        tick();
        checkValue("held_high_event", 8'(pending), 8'h1);
        ticks(2);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            applyStimulus(4'($urandom), ($urandom_range(0, 7) == 0),
                          4'($urandom), 1'($urandom_range(0, 1)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_irq_request_latch

// File: doc/irq_request_latch.md
Name: irq_request_latch

Overview:
- Captures rising edges on 2**N interrupt lines into sticky pending bits and applies a software-written enable mask.
- Each cycle, picks the lowest-index pending, unmasked source (index 0 = highest priority) and offers its index downstream over a valid/ready handshake.
- Sits between raw event lines and the consumer, such as a sequencer or interrupt handler, that acknowledges one request at a time.

Parameters:
- N, default 2, log2 of source count. 2**N sources; the index is N bits wide.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous assertion, active-low
- irq  input  2**N  event lines, already synchronous to clk; a 0->1 transition is an event
- mask_we  input  1  mask write strobe
- mask_wdata  input  2**N  new mask value; bit=1 blocks that source from being offered
- req_valid  output  1  an index is being offered
- req_id  output  N  offered source index; meaningful only while req_valid=1
- req_ready  input  1  consumer accepts the offered index
- pending  output  2**N  current pending bits, masked and unmasked
- mask  output  2**N  current mask register

Behaviour:
- Reset (rst_n=0, asynchronous): pending=0, mask=0 (all sources enabled), irq_q=0, req_valid=0, req_id=0, state=IDLE.
- Edge capture, every clock edge: irq_q <= irq. For each i, irq[i]=1 and irq_q[i]=0 sets pending[i].
- A line held high across reset release therefore registers one event on the first clock edge.
- Mask: on mask_we=1, mask <= mask_wdata at that edge. Masking never clears pending bits.
- Eligible vector: elig = pending & ~mask. none = (elig==0). sel = lowest set index of elig.
- FSM, 2 states:
  - IDLE: req_valid=0. If none=0, capture req_id <= sel and go to OFFER at the next edge.
  - OFFER: req_valid=1, req_id held constant. If req_ready=1 at an edge: clear pending[req_id] and return to IDLE.
- Latency: irq rises before edge k -> pending set at edge k -> req_valid=1 after edge k+1. Minimum spacing between two acceptances is 2 cycles (OFFER->IDLE->OFFER).
- Simultaneous set and clear on the same bit in the accepting cycle: set wins, bit stays pending, and the event is offered again later.
- A higher-priority source arriving during OFFER does not pre-empt. The offer stays stable until accepted; the new source is selected on the next IDLE pass.
- A mask write that blocks the offered source during OFFER does not withdraw the offer. The handshake completes normally.
- A second edge on an already-pending bit is merged; no counting.
- req_ready while in IDLE is ignored.
- Reset asserted mid-OFFER drops req_valid immediately (asynchronous) and discards all pending bits.

Optional Feature:
- Macro IRQ_OVERRUN_STATUS_EN.
- When defined: extra output port overrun (2**N).
  - overrun[i] sets when an edge arrives on source i while pending[i]=1.
  - overrun[i] clears when source i is accepted (req_valid & req_ready & req_id==i), unless a new overrun sets it in the same cycle; set wins.
  - Reset value 0.
- When undefined: no port and no register. Merged edges are silently dropped.

Decomposition:
- Package irq_pkg: state enum type (IDLE, OFFER), and a localparam function returning the source count 2**N.
- Sub-module lowest_set_index: purely combinational. Input vector of 2**N bits; outputs N-bit index of the lowest set bit plus a none flag; index=0 when none=1.
- Pending register, mask register, FSM and edge detection remain in irq_request_latch.

Test Plan (N=2):
- Reset then idle: irq=0000 for 10 cycles -> req_valid=0, pending=0000 throughout, mask=0000.
- Single event: irq 0000->0100 -> pending=0100 after 1 edge; req_valid=1, req_id=2 after the 2nd edge; hold req_ready=0 for 5 cycles -> outputs stable; assert req_ready=1 -> pending=0000, req_valid=0 next cycle.
- Priority order: irq rises 1010 and 0101 on the same cycle, req_ready held 1 -> accepted ids in order 0,1,2,3, each separated by exactly 2 cycles; pending ends 0000.
- No pre-emption: offering id=2; bit 0 rises -> req_id stays 2 until accepted; next offer is id=0.
- Mask: write mask=0001, then irq bit 0 rises -> pending=0001, req_valid stays 0; write mask=0000 -> req_id=0 offered 2 cycles later. Masking id 0 during its OFFER does not drop req_valid.
- Set/clear collision and overrun: accept id=1 on the same edge as a new irq[1] rise -> pending[1] stays 1 and is re-offered. With IRQ_OVERRUN_STATUS_EN defined: a second rise on bit 3 while pending -> overrun=1000, cleared on acceptance of id 3. Async reset mid-OFFER -> req_valid=0 without waiting for a clock edge.
